// File: rtl/nes_flash_reader.sv
// SPI flash word reader for the cartridge loader: 0xAB wake, then 0x03 reads in mode 0, streaming consecutive words.
// Latency (CLK_DIV=1): first word <= 2+CSH_CYCLES+128 clocks from acceptance, streamed word exactly 65 clocks.
// Backpressure: requests are sampled only in IDLE/STREAM; an accepted word always completes and ready pulses once.
//
// Ports:
//   clock, reset        system clock, synchronous active-high reset
//   valid, addr[23:0]   word request (byte address, addr[1:0] == 0)
//   ready, rdata[31:0]  one-cycle completion pulse, little-endian word (first flash byte in [7:0])
//   busy                high in every state except IDLE and STREAM
//   spi_cs/sclk/mosi    flash chip select (active low), SPI clock (idles low), serial data out
//   spi_miso            serial data from flash
module nes_flash_reader #(
    parameter int CLK_DIV     = 1,
    parameter int WAKE_CYCLES = 64,
    parameter int CSH_CYCLES  = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        valid,
    input  logic [23:0] addr,
    output logic        ready,
    output logic [31:0] rdata,
    output logic        busy,
    output logic        spi_cs,
    output logic        spi_sclk,
    output logic        spi_mosi,
    input  logic        spi_miso
);

    typedef enum logic [2:0] {
        WAKE_CMD,
        WAKE_WAIT,
        IDLE,
        CS_GAP,
        CMD,
        DATA,
        STREAM
    } state_t;

    localparam logic [8:0]  DIV_LAST  = 9'(2 * CLK_DIV - 1);
    localparam logic [8:0]  DIV_HI    = 9'(CLK_DIV);
    localparam logic [15:0] WAKE_LAST = 16'((WAKE_CYCLES > 0) ? WAKE_CYCLES - 1 : 0);
    localparam logic [31:0] WAKE_WORD = {8'hAB, 24'h000000};

    state_t      state, state_n;
    logic [8:0]  div_cnt, div_n;
    logic [4:0]  bit_cnt, bit_n;
    logic [31:0] tx_sr, tx_n;
    logic [30:0] rx_sr, rx_n;
    logic [23:0] cur_addr, cur_n;
    logic [23:0] next_addr, nxt_n;
    logic [15:0] wait_cnt, wait_n;
    logic [7:0]  csh_cnt;
    logic        cs_n, sclk_n, mosi_n, ready_n;
    logic [31:0] rdata_n;

    logic        bit_end;
    logic [8:0]  div_step;
    logic [31:0] cmd_word;
    logic [31:0] rx_full;
    logic        gap_done;

    assign busy = !((state == IDLE) || (state == STREAM));

    always_comb begin
        state_n  = state;
        div_n    = div_cnt;
        bit_n    = bit_cnt;
        tx_n     = tx_sr;
        rx_n     = rx_sr;
        cur_n    = cur_addr;
        nxt_n    = next_addr;
        wait_n   = wait_cnt;
        cs_n     = spi_cs;
        mosi_n   = spi_mosi;
        ready_n  = 1'b0;
        rdata_n  = rdata;
        bit_end  = (div_cnt == DIV_LAST);
        div_step = bit_end ? 9'd0 : div_cnt + 9'd1;
        cmd_word = {8'h03, cur_addr};
        rx_full  = {rx_sr, spi_miso};
        // csh_cnt is the number of earlier cycles cs has already been high; +1 counts this one.
        gap_done = (int'(csh_cnt) + 1 >= CSH_CYCLES);

        case (state)
            WAKE_CMD: begin
                if (spi_cs) begin
                    // First cycle after reset: drop cs and present bit 7 of 0xAB.
                    cs_n   = 1'b0;
                    mosi_n = WAKE_WORD[31];
                    tx_n   = {WAKE_WORD[30:0], 1'b0};
                    div_n  = 9'd0;
                    bit_n  = 5'd0;
                end else begin
                    div_n = div_step;
                    if (bit_end) begin
                        if (bit_cnt == 5'd7) begin
                            cs_n    = 1'b1;
                            mosi_n  = 1'b0;
                            wait_n  = 16'd0;
                            state_n = WAKE_WAIT;
                        end else begin
                            bit_n  = bit_cnt + 5'd1;
                            mosi_n = tx_sr[31];
                            tx_n   = {tx_sr[30:0], 1'b0};
                        end
                    end
                end
            end
            WAKE_WAIT: begin
                if (wait_cnt == WAKE_LAST) begin
                    state_n = IDLE;
                end else begin
                    wait_n = wait_cnt + 16'd1;
                end
            end
            IDLE: begin
                if (valid) begin
                    cur_n   = addr;
                    state_n = CS_GAP;
                end
            end
            CS_GAP: begin
                if (gap_done) begin
                    cs_n    = 1'b0;
                    mosi_n  = cmd_word[31];
                    tx_n    = {cmd_word[30:0], 1'b0};
                    div_n   = 9'd0;
                    bit_n   = 5'd0;
                    state_n = CMD;
                end
            end
            CMD: begin
                div_n = div_step;
                if (bit_end) begin
                    if (bit_cnt == 5'd31) begin
                        mosi_n  = 1'b0;
                        bit_n   = 5'd0;
                        state_n = DATA;
                    end else begin
                        bit_n  = bit_cnt + 5'd1;
                        mosi_n = tx_sr[31];
                        tx_n   = {tx_sr[30:0], 1'b0};
                    end
                end
            end
            DATA: begin
                div_n = div_step;
                if (bit_end) begin
                    rx_n = {rx_sr[29:0], spi_miso};
                    if (bit_cnt == 5'd31) begin
                        // rx_full holds the first received byte in its top byte.
                        rdata_n = {rx_full[7:0], rx_full[15:8], rx_full[23:16], rx_full[31:24]};
                        ready_n = 1'b1;
                        nxt_n   = cur_addr + 24'd4;
                        state_n = STREAM;
                    end else begin
                        bit_n = bit_cnt + 5'd1;
                    end
                end
            end
            STREAM: begin
                // The address held during the ready cycle belongs to the word just returned.
                if (valid && !ready) begin
                    cur_n = addr;
                    if (addr == next_addr) begin
                        div_n   = 9'd0;
                        bit_n   = 5'd0;
                        state_n = DATA;
                    end else begin
                        cs_n    = 1'b1;
                        state_n = CS_GAP;
                    end
                end
            end
            default: begin
                state_n = WAKE_CMD;
            end
        endcase

        sclk_n = !cs_n && ((state_n == WAKE_CMD) || (state_n == CMD) || (state_n == DATA))
                 && (div_n >= DIV_HI);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= WAKE_CMD;
            div_cnt   <= 9'd0;
            bit_cnt   <= 5'd0;
            tx_sr     <= 32'd0;
            rx_sr     <= 31'd0;
            cur_addr  <= 24'd0;
            next_addr <= 24'd0;
            wait_cnt  <= 16'd0;
            csh_cnt   <= 8'd0;
            spi_cs    <= 1'b1;
            spi_sclk  <= 1'b0;
            spi_mosi  <= 1'b0;
            ready     <= 1'b0;
            rdata     <= 32'd0;
        end else begin
            state     <= state_n;
            div_cnt   <= div_n;
            bit_cnt   <= bit_n;
            tx_sr     <= tx_n;
            rx_sr     <= rx_n;
            cur_addr  <= cur_n;
            next_addr <= nxt_n;
            wait_cnt  <= wait_n;
            spi_cs    <= cs_n;
            spi_sclk  <= sclk_n;
            spi_mosi  <= mosi_n;
            ready     <= ready_n;
            rdata     <= rdata_n;
            // Saturating count of cycles cs has been high; cleared whenever cs is low.
            if (!spi_cs) begin
                csh_cnt <= 8'd0;
            end else if (csh_cnt != 8'hFF) begin
                csh_cnt <= csh_cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_nes_flash_reader.sv
// Bench for nes_flash_reader: behavioural SPI flash, scoreboard of expected words, directed sequence.
// A second instance with CLK_DIV=3 is only used to measure SCK phase lengths during its wake command.
module tb_nes_flash_reader;

    logic        clock = 1'b0;
    always #5 clock = ~clock;

    logic        reset = 1'b1;
    logic        valid = 1'b0;
    logic [23:0] addr = 24'd0;
    logic        spi_miso = 1'b0;
    logic        ready, busy, spi_cs, spi_sclk, spi_mosi;
    logic [31:0] rdata;

    logic        reset3 = 1'b1;
    logic        valid3 = 1'b0;
    logic [23:0] addr3 = 24'd0;
    logic        miso3 = 1'b0;
    logic        ready3, busy3, cs3, sclk3, mosi3;
    logic [31:0] rdata3;

    nes_flash_reader dut (
        .clock(clock), .reset(reset), .valid(valid), .addr(addr), .ready(ready), .rdata(rdata),
        .busy(busy), .spi_cs(spi_cs), .spi_sclk(spi_sclk), .spi_mosi(spi_mosi), .spi_miso(spi_miso)
    );

    nes_flash_reader #(.CLK_DIV(3)) dut3 (
        .clock(clock), .reset(reset3), .valid(valid3), .addr(addr3), .ready(ready3), .rdata(rdata3),
        .busy(busy3), .spi_cs(cs3), .spi_sclk(sclk3), .spi_mosi(mosi3), .spi_miso(miso3)
    );

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic check_range(input string tag, input int obs, input int lo, input int hi);
        checks++;
        assert (obs >= lo && obs <= hi) else begin
            failures++;
            $error("FAIL %s observed=%0d expected in [%0d,%0d]", tag, obs, lo, hi);
        end
    endtask

    // Flash contents: 0x100000..0x100003 hold 0x11,0x22,0x33,0x44.
    function automatic logic [7:0] mb(input logic [23:0] a);
        int v;
        v = (int'(a[3:0]) + 1) * 17;
        return 8'(v) ^ a[11:4] ^ a[19:12];
    endfunction

    function automatic logic [31:0] exp_word(input logic [23:0] a);
        return {mb(a + 24'd3), mb(a + 24'd2), mb(a + 24'd1), mb(a)};
    endfunction

    // ---------------- flash model (mode 0) ----------------
    logic [31:0] cmd_sr = 32'd0;
    int          cmd_bits = 0;
    logic [23:0] faddr = 24'd0;
    int          data_bit = 0;
    bit          armed = 1'b0;
    bit          first_fall = 1'b0;
    logic        prev_sclk = 1'b0;
    logic [7:0]  fbyte;
    logic [31:0] cmds[$];

    always @(negedge clock) begin
        if (spi_cs) begin
            cmd_bits = 0;
            armed    = 1'b0;
        end else if (spi_sclk && !prev_sclk && !armed) begin
            cmd_sr = {cmd_sr[30:0], spi_mosi};
            cmd_bits++;
            if (cmd_bits == 8 && cmd_sr[7:0] == 8'hAB) cmds.push_back(32'hAB00_0000);
            if (cmd_bits == 32 && cmd_sr[31:24] == 8'h03) begin
                cmds.push_back(cmd_sr);
                faddr      = cmd_sr[23:0];
                armed      = 1'b1;
                first_fall = 1'b1;
            end
        end else if (!spi_sclk && prev_sclk && armed) begin
            if (first_fall) begin
                first_fall = 1'b0;
                data_bit   = 0;
            end else begin
                data_bit++;
                if (data_bit == 8) begin
                    data_bit = 0;
                    faddr    = faddr + 24'd1;
                end
            end
            fbyte    = mb(faddr);
            spi_miso = fbyte[7 - data_bit];
        end
        prev_sclk = spi_sclk;
    end

    // ---------------- monitor / scoreboard ----------------
    logic [31:0] exp_q[$];
    int          ready_count = 0;
    int          ready_cyc = 0;
    int          cs_rise_cnt = 0;
    int          cs_fall_cnt = 0;
    int          last_cs_rise = 0;
    int          cs_hi_run = 0;
    int          last_gap = 0;
    logic        prev_ready = 1'b0;
    logic        prev_reset = 1'b1;
    logic        prev_cs_m = 1'b1;
    logic [31:0] prev_rdata = 32'd0;
    logic [31:0] sb_exp;

    always @(negedge clock) begin
        if (!reset) begin
            if (ready) begin
                ready_count++;
                ready_cyc = cyc;
                check_range("sb_pending", exp_q.size(), 1, 1000);
                if (exp_q.size() > 0) begin
                    sb_exp = exp_q.pop_front();
                    check("sb_rdata", rdata, sb_exp);
                end
                check("ready_one_cycle", 32'(prev_ready), 32'd0);
            end else if (!prev_reset) begin
                check("rdata_stable", rdata, prev_rdata);
            end
        end
        if (spi_cs && !prev_cs_m) begin
            cs_rise_cnt++;
            last_cs_rise = cyc;
        end
        if (!spi_cs && prev_cs_m) begin
            cs_fall_cnt++;
            last_gap = cs_hi_run;
        end
        cs_hi_run  = spi_cs ? cs_hi_run + 1 : 0;
        prev_cs_m  = spi_cs;
        prev_ready = ready;
        prev_reset = reset;
        prev_rdata = rdata;
    end

    // SCK phase lengths of the CLK_DIV=3 instance, from cs fall to cs rise.
    int   phases[$];
    int   run_len = 0;
    bit   run_on = 1'b0;
    logic prev_cs3 = 1'b1;
    logic prev_sclk3 = 1'b0;

    always @(negedge clock) begin
        if (!cs3 && prev_cs3) begin
            run_len = 1;
            run_on  = 1'b1;
        end else if (run_on) begin
            if (sclk3 == prev_sclk3) begin
                run_len++;
            end else begin
                phases.push_back(run_len);
                run_len = 1;
            end
            if (cs3) run_on = 1'b0;
        end
        prev_cs3   = cs3;
        prev_sclk3 = sclk3;
    end

    // ---------------- helpers ----------------
    int acc_cyc = 0;

    task automatic tick();
        @(negedge clock);
        #1;
    endtask

    task automatic req(input logic [23:0] a);
        valid   = 1'b1;
        addr    = a;
        acc_cyc = cyc;
        exp_q.push_back(exp_word(a));
    endtask

    task automatic wait_ready(input int n, input int limit, input string tag);
        int i = 0;
        while (ready_count < n && i < limit) begin
            tick();
            i++;
        end
        check_range({tag, "_ready_count"}, ready_count, n, n);
    endtask

    task automatic wait_busy_low(input int limit, input string tag);
        int i = 0;
        while (busy !== 1'b0 && i < limit) begin
            tick();
            i++;
        end
        check({tag, "_busy_low"}, 32'(busy), 32'd0);
    endtask

    function automatic logic [31:0] last_cmd();
        return (cmds.size() > 0) ? cmds[cmds.size() - 1] : 32'hFFFF_FFFF;
    endfunction

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence ----------------
    initial begin
        int n_cmd, n_rise, n_fall, i;

        repeat (3) tick();
        check("rst_cs", 32'(spi_cs), 32'd1);
        check("rst_sclk", 32'(spi_sclk), 32'd0);
        check("rst_mosi", 32'(spi_mosi), 32'd0);
        check("rst_ready", 32'(ready), 32'd0);
        check("rst_rdata", rdata, 32'd0);
        check("rst_busy", 32'(busy), 32'd1);

        // Wake: 0xAB, cs rises, WAKE_CYCLES clocks, busy falls.
        reset  = 1'b0;
        reset3 = 1'b0;
        i = 0;
        while (cs_rise_cnt < 1 && i < 100) begin
            tick();
            i++;
        end
        check_range("wake_cs_rise", cs_rise_cnt, 1, 1);
        check("wake_cmd_count", cmds.size(), 32'd1);
        check("wake_cmd", last_cmd(), 32'hAB00_0000);
        wait_busy_low(200, "wake");
        check("wake_wait_len", 32'(cyc - last_cs_rise), 32'd64);
        check("no_ready_in_wake", ready_count, 32'd0);

        // First word from IDLE.
        req(24'h100000);
        wait_ready(1, 300, "w0");
        check_range("first_latency", ready_cyc - acc_cyc, 1, 2 + 4 + 128);
        check("w0_cmd", last_cmd(), 32'h0310_0000);
        check("w0_rdata", rdata, 32'h4433_2211);

        // Stream three more; the next address is presented the cycle after each ready.
        n_cmd  = cmds.size();
        n_rise = cs_rise_cnt;
        for (int k = 1; k <= 3; k++) begin
            tick();
            req(24'h100000 + 24'(4 * k));
            wait_ready(1 + k, 100, "stream");
            check("stream_latency", 32'(ready_cyc - acc_cyc), 32'd65);
        end
        check("stream_single_cmd", cmds.size(), 32'(n_cmd));
        check("stream_cs_low", cs_rise_cnt, 32'(n_rise));

        // Non-consecutive jump.
        tick();
        req(24'h140000);
        wait_ready(5, 300, "jump");
        check_range("jump_cs_gap", last_gap, 4, 1000);
        check("jump_cmd", last_cmd(), 32'h0314_0000);
        check("jump_cs_rise", cs_rise_cnt, 32'(n_rise + 1));
        check_range("jump_latency", ready_cyc - acc_cyc, 1, 2 + 4 + 128);

        // valid dropped mid-DATA: word still completes; STREAM holds cs low.
        tick();
        req(24'h140004);
        repeat (10) tick();
        valid = 1'b0;
        wait_ready(6, 100, "drop");
        check("drop_latency", 32'(ready_cyc - acc_cyc), 32'd65);
        n_cmd = cmds.size();
        repeat (30) tick();
        check("hold_cs_low", 32'(spi_cs), 32'd0);
        check("hold_one_ready", ready_count, 32'd6);
        check("hold_not_busy", 32'(busy), 32'd0);
        req(24'h140008);
        wait_ready(7, 100, "resume");
        check("resume_latency", 32'(ready_cyc - acc_cyc), 32'd65);
        check("resume_no_cmd", cmds.size(), 32'(n_cmd));

        // Address wrap 0xFFFFFC -> 0x000000 streams.
        tick();
        valid = 1'b0;
        repeat (3) tick();
        req(24'hFFFFFC);
        wait_ready(8, 300, "wrap0");
        check("wrap_cmd", last_cmd(), 32'h03FF_FFFC);
        n_cmd = cmds.size();
        tick();
        req(24'h000000);
        wait_ready(9, 100, "wrap1");
        check("wrap_latency", 32'(ready_cyc - acc_cyc), 32'd65);
        check("wrap_no_cmd", cmds.size(), 32'(n_cmd));

        // Reset in the middle of a command.
        tick();
        n_fall = cs_fall_cnt;
        valid  = 1'b1;
        addr   = 24'h200000;
        i = 0;
        while (cs_fall_cnt <= n_fall && i < 20) begin
            tick();
            i++;
        end
        check_range("abort_cmd_started", cs_fall_cnt, n_fall + 1, n_fall + 1);
        repeat (10) tick();
        reset = 1'b1;
        valid = 1'b0;
        tick();
        check("abort_cs", 32'(spi_cs), 32'd1);
        check("abort_sclk", 32'(spi_sclk), 32'd0);
        check("abort_ready", 32'(ready), 32'd0);
        check("abort_rdata", rdata, 32'd0);
        check("abort_busy", 32'(busy), 32'd1);
        n_cmd = cmds.size();
        repeat (2) tick();
        reset = 1'b0;
        wait_busy_low(300, "rewake");
        check("rewake_cmd_count", cmds.size(), 32'(n_cmd + 1));
        check("rewake_cmd", last_cmd(), 32'hAB00_0000);
        check("rewake_wait_len", 32'(cyc - last_cs_rise), 32'd64);
        check("rewake_ready_total", ready_count, 32'd9);

        // SCK phases of the CLK_DIV=3 instance during its wake command.
        check("ck3_phase_count", phases.size(), 32'd16);
        foreach (phases[j]) check("ck3_phase_len", phases[j], 32'd3);
        check("ck3_wake_mosi_idle", 32'(mosi3), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
